prio_enc_arb: RTL and testbench
===============================

# prio_enc_arb

Parametrised N-input priority encoder with a registered, handshaked output and a selectable fixed-priority or round-robin mode. It generalises the 4-to-2 combinational encoder to any power-of-two width. It adds a valid/ready output stage, a one-hot grant and a multiple-request flag. It sits between a bank of request lines (buttons, FIFO-not-empty flags, interrupt sources) and a single consumer that serves one index at a time.

## Interface
- N, 8: number of request inputs; power of two, 2..64.
- IDXW, 3: index width; must equal log2(N).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i asserts request from source i.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- ready  input  1  consumer accepts the presented index this cycle.
- valid  output  1  idx/onehot/multi hold a live result.
- idx  output  IDXW  encoded winning index.
- onehot  output  N  one-hot of idx when valid; all-zero when not valid.
- multi  output  1  more than one req bit was set when the held result was sampled.

## Operation
- Output stage is a single register slot.
- Define accept = valid & ready, and load = accept | ~valid.
- On load, the slot captures the current req:
  - valid <= |req.
  - idx <= winner.
  - onehot <= 1 << winner.
  - multi <= (popcount(req) > 1).
  - If req == 0, then valid <= 0, idx <= 0, onehot <= 0 and multi <= 0.
- When ~load (valid & ~ready), the slot holds all outputs unchanged. Changes on req are ignored, and dropping a request does not cancel a held grant.
- Fixed mode winner: highest set index of req.
- Round-robin mode winner: first set bit found searching upward from start, modulo N (start, start+1, …, N-1, 0, …, start-1).
  - start = accept ? (idx+1) mod N : ptr.
- Internal pointer ptr (IDXW bits): on accept, ptr <= (idx+1) mod N, regardless of mode. Otherwise ptr holds.
- Mode changes take effect at the next load. A held result is never re-evaluated.
- Reset: valid = 0, idx = 0, onehot = 0, multi = 0, ptr = 0. Reset overrides load and accept in the same cycle.

## Timing
- Latency: req sampled at edge k appears on outputs after edge k; 1 cycle.
- Throughput: one grant per cycle while ready = 1 and req ≠ 0.
- ready is not required to wait for valid. ready with valid = 0 has no effect beyond a normal load.
- Back-to-back accepts in round-robin mode use the accepted idx+1 as start in the same cycle, so the same source is never granted twice in a row while another is requesting.
- Wrap-around: accepting idx = N-1 sets start/ptr to 0.
- Single requester in round-robin mode is re-granted every cycle.
- Reset asserted mid-stall discards the held result. The first load after reset searches from index 0.
- No combinational path from req or mode to any output. ready affects only next-state logic.

## Test plan
- Reset (N=8): rst = 1 for 2 cycles with req = 8'hFF, ready = 1 -> valid = 0, idx = 0, onehot = 0, multi = 0 after each edge. On the first edge after release, valid = 1 and idx = 7.
- Fixed walk: mode = 0, ready = 1, req steps 01, 02, 04 … 80, then 00 -> idx = 0 … 7 one cycle after each step, onehot = req, multi = 0. Then valid = 0 and idx = 0.
- Fixed multi: mode = 0, req = 8'b1001_0110 -> idx = 7, onehot = 8'h80, multi = 1. With req = 8'b0001_0110 -> idx = 4, multi = 1.
- Round-robin fairness: mode = 1, ready = 1, from reset hold req = 8'b0010_0101 -> idx sequence 0, 2, 5, 0, 2, 5, with valid = 1 and multi = 1 throughout.
- Backpressure: mode = 0, ready = 0, req = 04, then req = 10 after one cycle -> idx = 2, valid = 1 held for every cycle ready stays 0. Pulse ready = 1 for one cycle -> idx = 4 on the next cycle.
- Reset mid-operation: mode = 1, drive ptr to 3 via accepts. Assert rst for 1 cycle with ready = 0 and valid = 1, then req = 8'hFF, ready = 1 -> outputs cleared during reset, then idx sequence 0, 1, 2.

Source files
------------

// File: rtl/prio_enc_arb.sv
// -----------------------------------------------------------------------------
// prio_enc_arb
//
// N-input priority encoder / arbiter with a single registered output slot and a
// valid/ready handshake. The winner is either the highest set request index
// (fixed mode) or the first set request found searching upward, with wrap,
// from a rotating start point (round-robin mode).
//
// Ports
//   clk     in   1     system clock, all state changes on the rising edge
//   rst     in   1     synchronous active-high reset
//   req     in   N     request vector, bit i = request from source i
//   mode    in   1     0 = fixed priority (highest index wins), 1 = round-robin
//   ready   in   1     consumer accepts the presented result this cycle
//   valid   out  1     idx/onehot/multi hold a live result
//   idx     out  IDXW  encoded winning index
//   onehot  out  N     one-hot of idx while valid, zero otherwise
//   multi   out  1     more than one request was set when the result was loaded
//
// Every output is driven straight from a register, so there is no
// combinational path from req, mode or ready to the outputs.
// -----------------------------------------------------------------------------
module prio_enc_arb #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            ready,
  output logic            valid,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    onehot,
  output logic            multi
);

  // Output slot and round-robin pointer
  logic            r_valid;
  logic [IDXW-1:0] r_idx;
  logic [N-1:0]    r_onehot;
  logic            r_multi;
  logic [IDXW-1:0] r_ptr;

  logic            w_accept;
  logic            w_load;
  logic [IDXW-1:0] w_start;
  logic [N-1:0]    w_rot;
  logic [IDXW-1:0] w_off;
  logic [IDXW-1:0] w_rr;
  logic [IDXW-1:0] w_fixed;
  logic [IDXW-1:0] w_winner;
  logic            w_any;
  logic            w_multi;
  logic [N-1:0]    w_onehot;

  assign w_accept = r_valid & ready;
  assign w_load   = w_accept | ~r_valid;

  // On an accept the search starts just past the index being consumed, so the
  // same source cannot win twice in a row while someone else is requesting.
  // IDXW-bit arithmetic wraps modulo N because N is a power of two.
  assign w_start = w_accept ? (r_idx + IDXW'(1)) : r_ptr;

  // Rotate req so that bit 0 of w_rot is the request at w_start; the
  // round-robin winner is then the lowest set bit of w_rot, offset by w_start.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot[gi] = req[w_start + IDXW'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDXW'(k);
    end
  end

  assign w_rr = w_start + w_off;

  // Fixed priority: ascending scan, so the highest set index is written last.
  always_comb begin
    w_fixed = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) w_fixed = IDXW'(k);
    end
  end

  assign w_any    = |req;
  assign w_winner = mode ? w_rr : w_fixed;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(req & (req - N'(1)));

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign w_onehot[gi] = w_any & (w_winner == IDXW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_multi  <= 1'b0;
      r_ptr    <= '0;
    end else begin
      // The pointer follows every accept, whatever the mode, so switching to
      // round-robin continues from just past the last consumed index.
      if (w_accept) r_ptr <= r_idx + IDXW'(1);
      // A held (valid, not accepted) result ignores req and mode entirely.
      if (w_load) begin
        r_valid  <= w_any;
        r_idx    <= w_any ? w_winner : '0;
        r_onehot <= w_onehot;
        r_multi  <= w_multi;
      end
    end
  end

  assign valid  = r_valid;
  assign idx    = r_idx;
  assign onehot = r_onehot;
  assign multi  = r_multi;

endmodule

// File: tb/tb_prio_enc_arb.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_arb
//
// Directed steps followed by randomized traffic for prio_enc_arb (N=8). A
// behavioural model tracks the output slot and round-robin pointer using plain
// integer searches; every cycle the DUT outputs are compared with it, and the
// directed steps additionally check hand-derived constant values.
// -----------------------------------------------------------------------------
module tb_prio_enc_arb;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            mode;
  logic            ready;
  logic            valid;
  logic [IDXW-1:0] idx;
  logic [N-1:0]    onehot;
  logic            multi;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  bit m_multi;
  int m_ptr;

  prio_enc_arb #(.N(N), .IDXW(IDXW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mode   (mode),
    .ready  (ready),
    .valid  (valid),
    .idx    (idx),
    .onehot (onehot),
    .multi  (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit accept;
    bit load;
    int cnt;
    int win;
    int start;
    int j;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_multi = 0; m_ptr = 0;
      return;
    end
    accept = m_valid && ready;
    load   = accept || !m_valid;
    start  = accept ? (m_idx + 1) % N : m_ptr;
    if (accept) m_ptr = (m_idx + 1) % N;
    if (!load) return;
    cnt = 0;
    for (int i = 0; i < N; i++) if (req[i]) cnt++;
    if (cnt == 0) begin
      m_valid = 0; m_idx = 0; m_multi = 0;
      return;
    end
    win = -1;
    if (!mode) begin
      for (int i = N - 1; i >= 0 && win < 0; i--) if (req[i]) win = i;
    end else begin
      for (int k = 0; k < N && win < 0; k++) begin
        j = (start + k) % N;
        if (req[j]) win = j;
      end
    end
    m_valid = 1;
    m_idx   = win;
    m_multi = (cnt > 1);
  endtask

  // One clock: update model, clock the DUT, compare all outputs off the edge.
  task automatic tick(input string tag);
    logic [N-1:0] exp_oh;
    model_step();
    @(posedge clk);
    #1;
    exp_oh = '0;
    if (m_valid) exp_oh[m_idx] = 1'b1;
    chk({tag, ".valid"},  64'(valid),  64'(m_valid));
    chk({tag, ".idx"},    64'(idx),    64'(m_idx));
    chk({tag, ".onehot"}, 64'(onehot), 64'(exp_oh));
    chk({tag, ".multi"},  64'(multi),  64'(m_multi));
    $display("%s req=%02h mode=%0d rdy=%0d rst=%0d -> valid=%0d idx=%0d onehot=%02h multi=%0d",
             tag, req, mode, ready, rst, valid, idx, onehot, multi);
  endtask

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; ready = 1'b0;
    m_valid = 0; m_idx = 0; m_multi = 0; m_ptr = 0;

    // Reset holds everything clear even with requests and ready present
    rst = 1'b1; req = 8'hFF; ready = 1'b1; mode = 1'b0;
    tick("rst0"); chk("rst0.valid_c", 64'(valid), 0); chk("rst0.onehot_c", 64'(onehot), 0);
    tick("rst1"); chk("rst1.idx_c", 64'(idx), 0);     chk("rst1.multi_c", 64'(multi), 0);
    rst = 1'b0;
    tick("rel");  chk("rel.valid_c", 64'(valid), 1);  chk("rel.idx_c", 64'(idx), 7);

    // Fixed walk of a single request bit
    for (int i = 0; i < N; i++) begin
      req = 8'(1 << i);
      tick("walk");
      chk("walk.idx_c", 64'(idx), 64'(i));
      chk("walk.onehot_c", 64'(onehot), 64'(req));
      chk("walk.multi_c", 64'(multi), 0);
    end
    req = 8'h00;
    tick("walk0"); chk("walk0.valid_c", 64'(valid), 0); chk("walk0.idx_c", 64'(idx), 0);

    // Fixed priority with several requesters
    req = 8'b1001_0110;
    tick("fm1"); chk("fm1.idx_c", 64'(idx), 7); chk("fm1.onehot_c", 64'(onehot), 64'h80);
    chk("fm1.multi_c", 64'(multi), 1);
    req = 8'b0001_0110;
    tick("fm2"); chk("fm2.idx_c", 64'(idx), 4); chk("fm2.multi_c", 64'(multi), 1);

    // Round-robin fairness from reset
    rst = 1'b1; tick("rrrst"); rst = 1'b0;
    mode = 1'b1; ready = 1'b1; req = 8'b0010_0101;
    for (int i = 0; i < 6; i++) begin
      int exp_seq [6] = '{0, 2, 5, 0, 2, 5};
      tick("rr");
      chk("rr.idx_c", 64'(idx), 64'(exp_seq[i]));
      chk("rr.multi_c", 64'(multi), 1);
    end

    // Backpressure holds the granted result despite req changes
    mode = 1'b0; ready = 1'b1; req = 8'h00; tick("bp_clr");
    ready = 1'b0; req = 8'h04; tick("bp0"); chk("bp0.idx_c", 64'(idx), 2);
    req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick("bp_hold");
      chk("bp_hold.idx_c", 64'(idx), 2);
      chk("bp_hold.valid_c", 64'(valid), 1);
    end
    ready = 1'b1; tick("bp_rel"); chk("bp_rel.idx_c", 64'(idx), 4);
    ready = 1'b0;

    // Reset mid-stall with pointer at 3
    rst = 1'b1; tick("mrst0"); rst = 1'b0;
    mode = 1'b1; ready = 1'b1; req = 8'hFF;
    for (int i = 0; i < 4; i++) tick("mrst_adv");
    chk("mrst_adv.idx_c", 64'(idx), 3);
    ready = 1'b0; tick("mrst_stall"); chk("mrst_stall.valid_c", 64'(valid), 1);
    rst = 1'b1; tick("mrst"); chk("mrst.valid_c", 64'(valid), 0); chk("mrst.idx_c", 64'(idx), 0);
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("mrst_seq");
      chk("mrst_seq.idx_c", 64'(idx), 64'(i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 8'(1 << $urandom_range(0, N - 1));
        default: req = 8'($urandom);
      endcase
      mode  = ($urandom_range(0, 7) != 0) ? mode : ~mode;
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 49) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
